// File: rtl/regfile_seq_ctrl_pkg.sv
// Shared types and constants for the register-file sequencer: opcodes, FSM states,
// ALU operation codes and the register data width.
package regfile_seq_ctrl_pkg;

    localparam int DATA_W = 512;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_MUL   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_MEM,
        ST_WB_LO,
        ST_WB_HI,
        ST_DONE
    } state_e;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_MUL = 1'b1
    } alu_op_e;

    // Opcodes 5..7 are reserved and complete immediately with an error.
    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// Bundle of the instruction, register-file, ALU and memory signals around the sequencer.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface regfile_seq_ctrl_if
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int AW = 16
) ();

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [1:0]        instr_rd;
    logic [1:0]        instr_rs1;
    logic [1:0]        instr_rs2;
    logic [AW-1:0]     instr_addr;

    logic              rf_we;
    logic [1:0]        rf_addr1;
    logic [1:0]        rf_addr2;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    logic              alu_start;
    logic              alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_res_lo;
    logic [DATA_W-1:0] alu_res_hi;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_addr,
        input  rf_rdata1, rf_rdata2,
        input  alu_done, alu_res_lo, alu_res_hi,
        input  mem_ack, mem_rdata,
        output instr_ready,
        output rf_we, rf_addr1, rf_addr2, rf_wdata,
        output alu_start, alu_op, alu_a, alu_b,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, done, err
    );

    modport slave (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_addr,
        output rf_rdata1, rf_rdata2,
        output alu_done, alu_res_lo, alu_res_hi,
        output mem_ack, mem_rdata,
        input  instr_ready,
        input  rf_we, rf_addr1, rf_addr2, rf_wdata,
        input  alu_start, alu_op, alu_a, alu_b,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, done, err
    );

endinterface

// File: rtl/regfile_seq_ctrl_wait_timer.sv
// Handshake wait timer: cleared while loaded, counts while running, and flags expiry
// on the TIMEOUT-th running cycle. TIMEOUT of zero never expires.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_run && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Single-issue sequencer for a 4x512-bit register file: operand read, ALU or memory
// handshake, then one write-back (two for the 1024-bit multiply result).
module regfile_seq_ctrl
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    regfile_seq_ctrl_if.master bus
);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [1:0]        r_rd;
    logic [1:0]        r_rs1;
    logic [1:0]        r_rs2;
    logic [AW-1:0]     r_addr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
    logic              r_err;
    logic              r_first;

    logic w_waiting;
    logic w_accept;
    logic w_handshake;
    logic w_expire;
    logic w_timeout;

    assign w_waiting   = (r_state == ST_EXEC) || (r_state == ST_MEM);
    assign w_accept    = (r_state == ST_IDLE) && bus.instr_valid;
    assign w_handshake = ((r_state == ST_EXEC) && bus.alu_done) ||
                         ((r_state == ST_MEM)  && bus.mem_ack);
    // A handshake on the expiry cycle wins over the timeout.
    assign w_timeout   = w_waiting && w_expire && !w_handshake;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (!w_waiting),
        .i_run    (w_waiting),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output and w_next gets a default before the case so no latch is inferred.
    always_comb begin
        w_next          = r_state;
        bus.instr_ready = 1'b0;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        bus.rf_we       = 1'b0;
        bus.rf_addr1    = 2'd0;
        bus.rf_addr2    = 2'd0;
        bus.rf_wdata    = '0;
        bus.alu_start   = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;

        case (r_state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                bus.busy        = 1'b0;
                if (bus.instr_valid) begin
                    case (bus.instr_op)
                        OP_LOAD:                   w_next = ST_MEM;
                        OP_STORE, OP_ADD, OP_MUL:  w_next = ST_READ;
                        default:                   w_next = ST_DONE;
                    endcase
                end
            end
            ST_READ: begin
                bus.rf_addr1 = r_rs1;
                bus.rf_addr2 = r_rs2;
                w_next       = (r_op == OP_STORE) ? ST_MEM : ST_EXEC;
            end
            ST_EXEC: begin
                bus.alu_start = r_first;
                bus.alu_op    = (r_op == OP_MUL) ? ALU_MUL : ALU_ADD;
                if (bus.alu_done) begin
                    w_next = ST_WB_LO;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = r_addr;
                if (r_op == OP_STORE) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = r_a;
                end
                if (bus.mem_ack) begin
                    w_next = (r_op == OP_LOAD) ? ST_WB_LO : ST_DONE;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_WB_LO: begin
                bus.rf_we    = 1'b1;
                bus.rf_wdata = r_lo;
                bus.rf_addr1 = (r_op == OP_MUL) ? {r_rd[1], 1'b0} : r_rd;
                w_next       = (r_op == OP_MUL) ? ST_WB_HI : ST_DONE;
            end
            ST_WB_HI: begin
                bus.rf_we    = 1'b1;
                bus.rf_wdata = r_hi;
                bus.rf_addr1 = {r_rd[1], 1'b1};
                w_next       = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                bus.err  = r_err;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: the wide operand/result registers are reset as well, so alu_a/alu_b read 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_NOP;
            r_rd    <= 2'd0;
            r_rs1   <= 2'd0;
            r_rs2   <= 2'd0;
            r_addr  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_first <= (w_next == ST_EXEC) && (r_state != ST_EXEC);
            if (w_accept) begin
                r_op   <= is_legal(bus.instr_op) ? op_e'(bus.instr_op) : OP_NOP;
                r_rd   <= bus.instr_rd;
                r_rs1  <= bus.instr_rs1;
                r_rs2  <= bus.instr_rs2;
                r_addr <= bus.instr_addr;
                r_err  <= !is_legal(bus.instr_op);
            end
            if (r_state == ST_READ) begin
                r_a <= bus.rf_rdata1;
                r_b <= bus.rf_rdata2;
            end
            if ((r_state == ST_EXEC) && bus.alu_done) begin
                r_lo <= bus.alu_res_lo;
                r_hi <= bus.alu_res_hi;
            end
            if ((r_state == ST_MEM) && bus.mem_ack && (r_op == OP_LOAD)) begin
                r_lo <= bus.mem_rdata;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.alu_a = r_a;
    assign bus.alu_b = r_b;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl: a small register-file model plus hand-driven
// ALU and memory responses; each comparison is an immediate assertion.
module tb_regfile_seq_ctrl;
    import regfile_seq_ctrl_pkg::*;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic              pre_we;
    logic [1:0]        pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] rf [4];
    logic [DATA_W-1:0] big;

    regfile_seq_ctrl_if #(.AW(AW)) bus ();

    regfile_seq_ctrl #(
        .AW      (AW),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: bench preload port, otherwise the DUT write port.
    always_ff @(posedge clk) begin
        if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end else if (bus.rf_we) begin
            rf[bus.rf_addr1] <= bus.rf_wdata;
        end
    end

    assign bus.rf_rdata1 = rf[bus.rf_addr1];
    assign bus.rf_rdata2 = rf[bus.rf_addr2];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input logic [1:0] a, input logic [DATA_W-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    // Offers one instruction in IDLE; returns one cycle later (T1) with valid dropped.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [AW-1:0] addr);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_addr  = addr;
        check("ready_at_issue", 512'(bus.instr_ready), 512'(1));
        step();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        pre_we         = 1'b0;
        pre_addr       = 2'd0;
        pre_data       = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op   = 3'd0;
        bus.instr_rd   = 2'd0;
        bus.instr_rs1  = 2'd0;
        bus.instr_rs2  = 2'd0;
        bus.instr_addr = '0;
        bus.alu_done   = 1'b0;
        bus.alu_res_lo = '0;
        bus.alu_res_hi = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        big            = '0;
        big[511]       = 1'b1;

        repeat (2) step();
        check("rst_ready", 512'(bus.instr_ready), 512'(1));
        check("rst_busy", 512'(bus.busy), 512'(0));
        check("rst_done", 512'(bus.done), 512'(0));
        check("rst_rf_we", 512'(bus.rf_we), 512'(0));
        check("rst_mem_req", 512'(bus.mem_req), 512'(0));
        check("rst_alu_start", 512'(bus.alu_start), 512'(0));
        check("rst_alu_a", bus.alu_a, 512'(0));
        reset = 1'b0;
        step();

        preload(2'd0, 512'(0));
        preload(2'd1, 512'(0));
        preload(2'd2, 512'(5));
        preload(2'd3, 512'(7));

        // ADD R1 = R2 + R3
        issue(3'd3, 2'd1, 2'd2, 2'd3, '0);
        check("add_t1_addr1", 512'(bus.rf_addr1), 512'(2));
        check("add_t1_addr2", 512'(bus.rf_addr2), 512'(3));
        check("add_t1_busy", 512'(bus.busy), 512'(1));
        check("add_t1_ready", 512'(bus.instr_ready), 512'(0));
        step();
        check("add_t2_start", 512'(bus.alu_start), 512'(1));
        check("add_t2_op", 512'(bus.alu_op), 512'(0));
        check("add_t2_a", bus.alu_a, 512'(5));
        check("add_t2_b", bus.alu_b, 512'(7));
        step();
        check("add_t3_start_once", 512'(bus.alu_start), 512'(0));
        bus.alu_done   = 1'b1;
        bus.alu_res_lo = 512'(12);
        bus.alu_res_hi = '0;
        step();
        bus.alu_done = 1'b0;
        check("add_t4_we", 512'(bus.rf_we), 512'(1));
        check("add_t4_addr1", 512'(bus.rf_addr1), 512'(1));
        check("add_t4_wdata", bus.rf_wdata, 512'(12));
        check("add_t4_done", 512'(bus.done), 512'(0));
        step();
        check("add_t5_done", 512'(bus.done), 512'(1));
        check("add_t5_err", 512'(bus.err), 512'(0));
        check("add_t5_we", 512'(bus.rf_we), 512'(0));
        step();
        check("add_t6_ready", 512'(bus.instr_ready), 512'(1));
        check("add_t6_done", 512'(bus.done), 512'(0));
        check("add_r1", rf[1], 512'(12));

        // MUL R3:R2 = R0 * R1 with R0 = 2^511, R1 = 4
        preload(2'd0, big);
        preload(2'd1, 512'(4));
        issue(3'd4, 2'd2, 2'd0, 2'd1, '0);
        step();
        check("mul_start", 512'(bus.alu_start), 512'(1));
        check("mul_op", 512'(bus.alu_op), 512'(1));
        check("mul_a", bus.alu_a, big);
        check("mul_b", bus.alu_b, 512'(4));
        step();
        check("mul_op_held", 512'(bus.alu_op), 512'(1));
        check("mul_start_once", 512'(bus.alu_start), 512'(0));
        step();
        bus.alu_done   = 1'b1;
        bus.alu_res_lo = '0;
        bus.alu_res_hi = 512'(2);
        step();
        bus.alu_done = 1'b0;
        check("mul_wlo_we", 512'(bus.rf_we), 512'(1));
        check("mul_wlo_addr", 512'(bus.rf_addr1), 512'(2));
        check("mul_wlo_data", bus.rf_wdata, 512'(0));
        step();
        check("mul_whi_we", 512'(bus.rf_we), 512'(1));
        check("mul_whi_addr", 512'(bus.rf_addr1), 512'(3));
        check("mul_whi_data", bus.rf_wdata, 512'(2));
        step();
        check("mul_done", 512'(bus.done), 512'(1));
        check("mul_err", 512'(bus.err), 512'(0));
        step();
        check("mul_r2", rf[2], 512'(0));
        check("mul_r3", rf[3], 512'(2));

        // LOAD R0 from 0x0040, ack on the third request cycle
        issue(3'd1, 2'd0, 2'd0, 2'd0, 16'h0040);
        check("ld_addr", 512'(bus.mem_addr), 512'(16'h0040));
        check("ld_we", 512'(bus.mem_we), 512'(0));
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("ld_req_%0d", i), 512'(bus.mem_req), 512'(1));
            if (i == 3) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 512'(16'hDEAD);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        check("ld_req_drop", 512'(bus.mem_req), 512'(0));
        check("ld_we_rf", 512'(bus.rf_we), 512'(1));
        check("ld_addr1", 512'(bus.rf_addr1), 512'(0));
        check("ld_wdata", bus.rf_wdata, 512'(16'hDEAD));
        step();
        check("ld_done", 512'(bus.done), 512'(1));
        check("ld_err", 512'(bus.err), 512'(0));
        step();
        check("ld_r0", rf[0], 512'(16'hDEAD));

        // STORE R0 to 0x0080
        issue(3'd2, 2'd0, 2'd0, 2'd0, 16'h0080);
        check("st_read_addr1", 512'(bus.rf_addr1), 512'(0));
        check("st_read_noreq", 512'(bus.mem_req), 512'(0));
        step();
        check("st_req", 512'(bus.mem_req), 512'(1));
        check("st_we", 512'(bus.mem_we), 512'(1));
        check("st_wdata", bus.mem_wdata, 512'(16'hDEAD));
        check("st_addr", 512'(bus.mem_addr), 512'(16'h0080));
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("st_done", 512'(bus.done), 512'(1));
        check("st_err", 512'(bus.err), 512'(0));
        check("st_no_rf_we", 512'(bus.rf_we), 512'(0));
        step();

        // Illegal opcode 6, then NOP
        issue(3'd6, 2'd1, 2'd0, 2'd0, '0);
        check("ill_done", 512'(bus.done), 512'(1));
        check("ill_err", 512'(bus.err), 512'(1));
        check("ill_we", 512'(bus.rf_we), 512'(0));
        check("ill_req", 512'(bus.mem_req), 512'(0));
        check("ill_start", 512'(bus.alu_start), 512'(0));
        step();
        check("ill_ready", 512'(bus.instr_ready), 512'(1));
        issue(3'd0, 2'd1, 2'd0, 2'd0, '0);
        check("nop_done", 512'(bus.done), 512'(1));
        check("nop_err", 512'(bus.err), 512'(0));
        step();

        // LOAD timeout (TIMEOUT=4): no ack ever
        issue(3'd1, 2'd1, 2'd0, 2'd0, 16'h0010);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_req_%0d", i), 512'(bus.mem_req), 512'(1));
            step();
        end
        check("to_done", 512'(bus.done), 512'(1));
        check("to_err", 512'(bus.err), 512'(1));
        check("to_we", 512'(bus.rf_we), 512'(0));
        check("to_req_drop", 512'(bus.mem_req), 512'(0));
        step();
        check("to_r1_kept", rf[1], 512'(4));

        // LOAD with ack on the expiry cycle counts as success
        issue(3'd1, 2'd1, 2'd0, 2'd0, 16'h0010);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("tx_req_%0d", i), 512'(bus.mem_req), 512'(1));
            if (i == 4) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 512'(16'h1234);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        check("tx_we", 512'(bus.rf_we), 512'(1));
        check("tx_wdata", bus.rf_wdata, 512'(16'h1234));
        step();
        check("tx_done", 512'(bus.done), 512'(1));
        check("tx_err", 512'(bus.err), 512'(0));
        step();

        // Reset during EXEC of a MUL; a late alu_done must be ignored
        issue(3'd4, 2'd3, 2'd2, 2'd3, '0);
        step();
        check("rs_in_exec", 512'(bus.alu_start), 512'(1));
        reset = 1'b1;
        #1;
        check("rs_ready", 512'(bus.instr_ready), 512'(1));
        check("rs_busy", 512'(bus.busy), 512'(0));
        check("rs_alu_a", bus.alu_a, 512'(0));
        step();
        reset          = 1'b0;
        bus.alu_done   = 1'b1;
        bus.alu_res_lo = 512'(5);
        bus.alu_res_hi = 512'(6);
        step();
        bus.alu_done = 1'b0;
        check("rs_late_we", 512'(bus.rf_we), 512'(0));
        check("rs_late_done", 512'(bus.done), 512'(0));
        check("rs_late_busy", 512'(bus.busy), 512'(0));
        step();
        check("rs_after_we", 512'(bus.rf_we), 512'(0));
        check("rs_after_done", 512'(bus.done), 512'(0));
        check("rs_r2_kept", rf[2], 512'(0));
        check("rs_r3_kept", rf[3], 512'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
